// File: rtl/menu_ctrl.sv
// Title-menu / game-flow screen sequencer: key edge detection, menu selection with
// frame-synchronous highlight blink, timed fade to gameplay, and game_start pulse.
module menu_ctrl #(
  parameter int         N_ITEMS          = 3,
  parameter int         BLINK_FRAMES     = 16,
  parameter int         FADE_STEP_FRAMES = 2,
  parameter logic [7:0] KEY_UP           = 8'h52,
  parameter logic [7:0] KEY_DOWN         = 8'h51,
  parameter logic [7:0] KEY_ENTER        = 8'h28,
  parameter logic [7:0] KEY_ESC          = 8'h29
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       game_over,
  output logic [1:0] screen,
  output logic [1:0] sel_item,
  output logic       highlight_on,
  output logic [3:0] fade_level,
  output logic       game_start
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int FW = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_STEP_FRAMES - 1);
  localparam logic [1:0]    SEL_LAST   = 2'(N_ITEMS - 1);

  // Low two bits of the encoding double as the reported screen code.
  typedef enum logic [2:0] {
    S_MENU = 3'd0,
    S_HELP = 3'd1,
    S_GAME = 3'd2,
    S_OVER = 3'd3,
    S_FADE = 3'd4
  } state_t;

  state_t        r_state, w_state_n;
  logic [1:0]    r_screen, w_screen_n;
  logic [1:0]    r_sel, w_sel_n;
  logic          r_hl, w_hl_n;
  logic [3:0]    r_fade, w_fade_n;
  logic          r_start, w_start_n;
  logic [BW-1:0] r_bcnt, w_bcnt_n;
  logic [FW-1:0] r_fcnt, w_fcnt_n;
  logic [7:0]    r_key_q;

  logic w_ev_up, w_ev_down, w_ev_enter, w_ev_esc;

  // A key only counts on the cycle its code first appears.
  assign w_ev_up    = (keycode == KEY_UP)    && (keycode != r_key_q);
  assign w_ev_down  = (keycode == KEY_DOWN)  && (keycode != r_key_q);
  assign w_ev_enter = (keycode == KEY_ENTER) && (keycode != r_key_q);
  assign w_ev_esc   = (keycode == KEY_ESC)   && (keycode != r_key_q);

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state  <= S_MENU;
      r_screen <= 2'd0;
      r_sel    <= 2'd0;
      r_hl     <= 1'b1;
      r_fade   <= 4'hF;
      r_start  <= 1'b0;
      r_bcnt   <= '0;
      r_fcnt   <= '0;
      r_key_q  <= 8'h00;
    end else begin
      r_state  <= w_state_n;
      r_screen <= w_screen_n;
      r_sel    <= w_sel_n;
      r_hl     <= w_hl_n;
      r_fade   <= w_fade_n;
      r_start  <= w_start_n;
      r_bcnt   <= w_bcnt_n;
      r_fcnt   <= w_fcnt_n;
      r_key_q  <= keycode;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_hl_n    = r_hl;
    w_fade_n  = r_fade;
    w_start_n = 1'b0;
    w_bcnt_n  = r_bcnt;
    w_fcnt_n  = r_fcnt;
    if (r_state != S_MENU) begin
      w_hl_n   = 1'b1;
      w_bcnt_n = '0;
    end
    case (r_state)
      S_MENU: begin
        if (frame_tick) begin
          if (r_bcnt == BLINK_LAST) begin
            w_bcnt_n = '0;
            w_hl_n   = ~r_hl;
          end else begin
            w_bcnt_n = r_bcnt + 1'b1;
          end
        end
        // A selection change beats a coincident blink toggle.
        if (w_ev_up || w_ev_down) begin
          if (w_ev_up) w_sel_n = (r_sel == 2'd0) ? SEL_LAST : r_sel - 2'd1;
          else         w_sel_n = (r_sel == SEL_LAST) ? 2'd0 : r_sel + 2'd1;
          w_hl_n   = 1'b1;
          w_bcnt_n = '0;
        end else if (w_ev_enter && r_sel == 2'd0) begin
          w_state_n = S_FADE;
          w_fade_n  = 4'hF;
          w_fcnt_n  = '0;
          w_hl_n    = 1'b1;
          w_bcnt_n  = '0;
        end else if (w_ev_enter && r_sel == 2'd1) begin
          w_state_n = S_HELP;
          w_hl_n    = 1'b1;
          w_bcnt_n  = '0;
        end
      end
      S_FADE: begin
        if (frame_tick) begin
          if (r_fcnt == FADE_LAST) begin
            w_fcnt_n = '0;
            if (r_fade == 4'd0) begin
              w_state_n = S_GAME;
              w_start_n = 1'b1;
              w_fade_n  = 4'hF;
            end else begin
              w_fade_n = r_fade - 4'd1;
            end
          end else begin
            w_fcnt_n = r_fcnt + 1'b1;
          end
        end
      end
      S_GAME: begin
        if (game_over) begin
          w_state_n = S_OVER;
        end else if (w_ev_esc) begin
          w_state_n = S_MENU;
          w_sel_n   = 2'd0;
        end
      end
      S_OVER: begin
        if (w_ev_enter || w_ev_esc) begin
          w_state_n = S_MENU;
          w_sel_n   = 2'd0;
        end
      end
      S_HELP: begin
        if (w_ev_enter || w_ev_esc) w_state_n = S_MENU;
      end
      default: w_state_n = S_MENU;
    endcase
    w_screen_n = (w_state_n == S_FADE) ? 2'd0 : w_state_n[1:0];
  end

  assign screen       = r_screen;
  assign sel_item     = r_sel;
  assign highlight_on = r_hl;
  assign fade_level   = r_fade;
  assign game_start   = r_start;

endmodule

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
Top-level screen sequencer for the title menu and game flow. Decodes keyboard keycodes into one-shot navigation events, tracks the highlighted menu item with a frame-synchronous blink, and runs a timed fade-out before gameplay starts. Drives screen-select, highlight and fade outputs consumed by the menu renderer and the colour mapper, and emits a one-cycle game_start pulse to the game logic.

Parameters:
N_ITEMS, 3, number of menu items; index 0 = START, 1 = HELP, 2..N_ITEMS-1 = inert
BLINK_FRAMES, 16, frame ticks per highlight toggle
FADE_STEP_FRAMES, 2, frame ticks per fade_level decrement
KEY_UP, 8'h52, HID keycode for up
KEY_DOWN, 8'h51, HID keycode for down
KEY_ENTER, 8'h28, HID keycode for enter
KEY_ESC, 8'h29, HID keycode for escape

Ports:
vga_clk  in  1  pixel/system clock; all logic on its rising edge
reset_n  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle pulse per frame (start of vertical blank)
keycode  in  8  current HID keycode; 0 = no key
game_over  in  1  one-cycle pulse from game logic
screen  out  2  0 MENU, 1 HELP, 2 GAME, 3 OVER (FADE state reports 0)
sel_item  out  2  highlighted item index
highlight_on  out  1  highlight visible this frame
fade_level  out  4  brightness scale; 15 = full, 0 = black
game_start  out  1  one-cycle pulse on entry to GAME

Behaviour:
- Reset is synchronous and active-low: while reset_n = 0 at a rising edge, state = MENU, sel_item = 0, highlight_on = 1, fade_level = 15, game_start = 0, blink counter = 0, fade counter = 0, key_q = 0.
- Key event: key_q <= keycode every cycle. ev_X = (keycode == KEY_X) && (keycode != key_q). A held key produces exactly one event; a release to 0 followed by a re-press produces a new event. A direct change from one non-zero code to another is also an event.
- All outputs are registered. Event at cycle n updates the outputs after the edge ending cycle n, giving 1-cycle latency.
- MENU:
  - ev_UP sets sel = (sel == 0) ? N_ITEMS-1 : sel-1.
  - ev_DOWN sets sel = (sel == N_ITEMS-1) ? 0 : sel+1.
  - Any sel change forces highlight_on = 1 and blink counter = 0.
  - ev_ENTER with sel 0 goes to FADE; fade_level = 15, fade counter = 0.
  - ev_ENTER with sel 1 goes to HELP.
  - ev_ENTER with any other sel is ignored.
  - Blink: on frame_tick, counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and highlight_on toggles.
- FADE:
  - Keys ignored; highlight_on held at 1.
  - On frame_tick the fade counter increments. At FADE_STEP_FRAMES-1 it wraps and fade_level decrements.
  - The step that would take fade_level below 0 (fade_level == 0 at the step) instead moves to GAME, asserts game_start for exactly that one cycle, and restores fade_level = 15.
  - Total fade = 16*FADE_STEP_FRAMES frame ticks.
- GAME:
  - game_over goes to OVER.
  - Otherwise ev_ESC goes to MENU with sel = 0.
  - game_over and ev_ESC in the same cycle: game_over wins.
- OVER: ev_ENTER or ev_ESC goes to MENU, sel = 0, highlight_on = 1, blink counter = 0.
- HELP: ev_ENTER or ev_ESC goes to MENU; sel is preserved.
- frame_tick coincident with a key event: both are processed in the same cycle. A sel change overrides the blink toggle, so the result is highlight_on = 1 and counter = 0.
- Blink counter runs only in MENU. In other states it is held at 0, and highlight_on is held at 1.
- game_over outside GAME is ignored.
- Reset mid-fade or mid-game returns to the reset values on the next edge. game_start is never asserted during reset.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, release -> screen = 0, sel_item = 0, highlight_on = 1, fade_level = 15, game_start = 0.
- Navigation wrap: press DOWN, release, repeated 3 times -> sel 1, 2, 0. Press UP from 0 -> sel = 2. Hold DOWN for 50 cycles -> only one increment.
- Blink: idle in MENU with 40 frame_ticks -> highlight_on toggles after ticks 16 and 32 (1→0→1). Pressing DOWN on tick 16 -> highlight_on stays 1 and the counter restarts.
- Start fade: sel = 0, press ENTER, apply 32 frame_ticks -> fade_level steps 15→0 every 2 ticks. On tick 32, screen = 2, game_start is high for exactly 1 cycle, fade_level = 15. Keys pressed during the fade have no effect.
- Help / game-over flow: sel = 1 + ENTER -> screen = 1; ESC -> screen = 0 with sel = 1. In GAME, game_over and ESC in the same cycle -> screen = 3. Then ENTER -> screen = 0, sel = 0.
- Reset mid-operation: assert reset_n = 0 at fade_level = 7 -> next edge screen = 0, fade_level = 15, and no game_start pulse.
